prog_clkdiv: RTL and testbench

Multi-channel programmable integer clock divider: the parametrised successor to the fixed ripple divide-by-2^n chain. Each of NUM_CH channels produces a divided clock-enable waveform `clkout[i]` of ratio D (2..2^DIV_W-1) plus a one-cycle `tick[i]` at each rising edge. All logic is synchronous to the single fast clock `clk`. Ratios change glitch-free at period boundaries, and a global sync request phase-aligns all channels.

---
 rtl/prog_clkdiv.sv | 213 +++++++++++++++++++++
 tb/tb_prog_clkdiv.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clkdiv.sv
// -----------------------------------------------------------------------------
// prog_clkdiv
// Multi-channel programmable integer clock divider. Every channel turns the
// fast clock into a divided clock-enable waveform of ratio D (2..2^DIV_W-1).
// It also produces a one-cycle tick in the first high cycle of each period.
// Ratio changes on a running channel are held in a shadow register and take
// effect only at the end of the current period, so no output glitches. A
// global sync request restarts every enabled channel in phase.
//
// Ports
//   clk        in   1       fast clock, all state changes on posedge
//   rst        in   1       synchronous active-high reset
//   cfg_valid  in   1       configuration write request
//   cfg_ready  out  1       write accepted when cfg_valid && cfg_ready
//   cfg_ch     in   CH_W    target channel (out-of-range writes are dropped)
//   cfg_div    in   DIV_W   requested ratio (0 and 1 are stored as 2)
//   cfg_en     in   1       1 = channel runs, 0 = channel stops
//   sync_req   in   1       restart all enabled channels in phase
//   clkout     out  NUM_CH  divided waveform per channel (registered)
//   tick       out  NUM_CH  first-high-cycle pulse per channel (registered)
//   pending    out  NUM_CH  channel holds an accepted, unapplied config
// -----------------------------------------------------------------------------
module prog_clkdiv #(
   parameter  int NUM_CH = 4,
   parameter  int DIV_W  = 8,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_en,
   input  logic              sync_req,
   output logic [NUM_CH-1:0] clkout,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pending
);

   // Bit 1 of the encoding marks "shadow config waiting"; bit 0 marks "running".
   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_RUN      = 2'b01,
      ST_RUN_PEND = 2'b11
   } ch_state_t;

   ch_state_t          r_state   [NUM_CH];
   logic [DIV_W-1:0]   r_cnt     [NUM_CH];
   logic [DIV_W-1:0]   r_div     [NUM_CH];
   logic [DIV_W-1:0]   r_sh_div  [NUM_CH];
   logic               r_sh_en   [NUM_CH];
   logic [NUM_CH-1:0]  r_clkout;
   logic [NUM_CH-1:0]  r_tick;

   ch_state_t          w_state_n  [NUM_CH];
   logic [DIV_W-1:0]   w_cnt_n    [NUM_CH];
   logic [DIV_W-1:0]   w_div_n    [NUM_CH];
   logic [DIV_W-1:0]   w_sh_div_n [NUM_CH];
   logic               w_sh_en_n  [NUM_CH];
   logic [DIV_W:0]     w_half     [NUM_CH];
   logic [NUM_CH-1:0]  w_wr;
   logic [NUM_CH-1:0]  w_wrap;
   logic [NUM_CH-1:0]  w_clkout_n;
   logic [NUM_CH-1:0]  w_tick_n;
   logic [DIV_W-1:0]   w_div_in;
   logic               w_ready;

   // Ratio clamp: anything below 2 would make a degenerate waveform.
   assign w_div_in = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

   // Handshake: only a channel with a waiting shadow config stalls the port;
   // writes addressed past the last channel are always accepted and dropped.
   always_comb begin
      w_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            w_ready = (r_state[i] != ST_RUN_PEND);
         end else begin
            w_ready = w_ready;
         end
      end
   end

   assign cfg_ready = w_ready;

   // Per-channel next-state logic: sync has priority, then wrap/write, then counting.
   always_comb begin
      w_wr       = '0;
      w_wrap     = '0;
      w_clkout_n = '0;
      w_tick_n   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_state_n[i]  = r_state[i];
         w_cnt_n[i]    = r_cnt[i];
         w_div_n[i]    = r_div[i];
         w_sh_div_n[i] = r_sh_div[i];
         w_sh_en_n[i]  = r_sh_en[i];
         w_half[i]     = '0;

         w_wr[i]   = cfg_valid && (cfg_ch == CH_W'(i)) && (r_state[i] != ST_RUN_PEND);
         w_wrap[i] = (r_cnt[i] == (r_div[i] - DIV_W'(1)));

         if (sync_req) begin
            // A shadow config, or a write landing on this very edge, is folded in.
            case (r_state[i])
               ST_RUN_PEND: begin
                  w_div_n[i]   = r_sh_div[i];
                  w_state_n[i] = r_sh_en[i] ? ST_RUN : ST_IDLE;
               end
               ST_RUN: begin
                  if (w_wr[i]) begin
                     w_div_n[i]   = w_div_in;
                     w_state_n[i] = cfg_en ? ST_RUN : ST_IDLE;
                  end else begin
                     w_state_n[i] = ST_RUN;
                  end
               end
               ST_IDLE: begin
                  if (w_wr[i]) begin
                     w_div_n[i]   = w_div_in;
                     w_state_n[i] = cfg_en ? ST_RUN : ST_IDLE;
                  end else begin
                     w_state_n[i] = ST_IDLE;
                  end
               end
               default: begin
                  w_state_n[i] = ST_IDLE;
               end
            endcase
            w_cnt_n[i] = '0;
         end else begin
            case (r_state[i])
               ST_IDLE: begin
                  if (w_wr[i]) begin
                     w_div_n[i]   = w_div_in;
                     w_state_n[i] = cfg_en ? ST_RUN : ST_IDLE;
                     w_cnt_n[i]   = '0;
                  end else begin
                     w_state_n[i] = ST_IDLE;
                  end
               end
               ST_RUN: begin
                  w_cnt_n[i] = w_wrap[i] ? '0 : (r_cnt[i] + DIV_W'(1));
                  // A write on a wrap edge still waits for the next wrap.
                  if (w_wr[i]) begin
                     w_sh_div_n[i] = w_div_in;
                     w_sh_en_n[i]  = cfg_en;
                     w_state_n[i]  = ST_RUN_PEND;
                  end else begin
                     w_state_n[i]  = ST_RUN;
                  end
               end
               ST_RUN_PEND: begin
                  if (w_wrap[i]) begin
                     w_div_n[i]   = r_sh_div[i];
                     w_state_n[i] = r_sh_en[i] ? ST_RUN : ST_IDLE;
                     w_cnt_n[i]   = '0;
                  end else begin
                     w_cnt_n[i]   = r_cnt[i] + DIV_W'(1);
                  end
               end
               default: begin
                  w_state_n[i] = ST_IDLE;
                  w_cnt_n[i]   = '0;
               end
            endcase
         end

         // High phase length is ceil(D/2); one extra bit avoids overflow at D=2^DIV_W-1.
         w_half[i]     = ({1'b0, w_div_n[i]} + (DIV_W+1)'(1)) >> 1;
         w_clkout_n[i] = (w_state_n[i] != ST_IDLE) && ({1'b0, w_cnt_n[i]} < w_half[i]);
         w_tick_n[i]   = (w_state_n[i] != ST_IDLE) && (w_cnt_n[i] == DIV_W'(0));
      end
   end

   // State, counters, ratio/shadow registers and the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_state[i]  <= ST_IDLE;
            r_cnt[i]    <= '0;
            r_div[i]    <= DIV_W'(2);
            r_sh_div[i] <= DIV_W'(2);
            r_sh_en[i]  <= 1'b0;
         end
         r_clkout <= '0;
         r_tick   <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_state[i]  <= w_state_n[i];
            r_cnt[i]    <= w_cnt_n[i];
            r_div[i]    <= w_div_n[i];
            r_sh_div[i] <= w_sh_div_n[i];
            r_sh_en[i]  <= w_sh_en_n[i];
         end
         r_clkout <= w_clkout_n;
         r_tick   <= w_tick_n;
      end
   end

   // Pending flag is the "shadow waiting" bit of each channel state.
   always_comb begin
      pending = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pending[i] = (r_state[i] == ST_RUN_PEND);
      end
   end

   assign clkout = r_clkout;
   assign tick   = r_tick;

endmodule

// File: tb/tb_prog_clkdiv.sv
// -----------------------------------------------------------------------------
// tb_prog_clkdiv
// Self-checking bench for prog_clkdiv. A period/phase model (each running
// channel is described by its ratio and the cycle its current period train
// started) predicts clkout, tick, pending and cfg_ready every cycle; directed
// captures compare against hand-written waveforms.
// -----------------------------------------------------------------------------
module tb_prog_clkdiv;

   localparam int NUM_CH = 4;
   localparam int DIV_W  = 8;

   logic              clk;
   logic              rst;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic              cfg_en;
   logic              sync_req;
   logic [NUM_CH-1:0] clkout;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] pending;

   int n_checks = 0;
   int n_errors = 0;

   prog_clkdiv #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_en    (cfg_en),
      .sync_req  (sync_req),
      .clkout    (clkout),
      .tick      (tick),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   int m_run   [NUM_CH];
   int m_d     [NUM_CH];
   int m_start [NUM_CH];
   int m_pend  [NUM_CH];
   int m_shd   [NUM_CH];
   int m_shen  [NUM_CH];
   int cyc_n = 0;
   bit m_ok  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   // Apply one clock edge to the model using the inputs the DUT sampled.
   task automatic model_edge();
      int  n;
      int  d;
      bit  acc;
      cyc_n++;
      n = cyc_n;
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_run[c] = 0; m_d[c] = 2; m_start[c] = n; m_pend[c] = 0;
            m_shd[c] = 2; m_shen[c] = 0;
         end
         m_ok = 1'b1;
         return;
      end
      d   = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
      acc = cfg_valid && ((int'(cfg_ch) >= NUM_CH) || (m_pend[cfg_ch] == 0));
      if (sync_req) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (m_pend[c] != 0) begin
               m_d[c] = m_shd[c]; m_run[c] = m_shen[c];
            end else if (acc && int'(cfg_ch) == c) begin
               m_d[c] = d; m_run[c] = int'(cfg_en);
            end
            m_start[c] = n;
            m_pend[c]  = 0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            // A period ends whenever a whole number of periods has elapsed.
            if (m_run[c] != 0 && m_pend[c] != 0 && ((n - m_start[c]) % m_d[c]) == 0) begin
               m_d[c] = m_shd[c]; m_run[c] = m_shen[c];
               m_start[c] = n; m_pend[c] = 0;
            end
            if (acc && int'(cfg_ch) == c) begin
               if (m_run[c] == 0) begin
                  m_d[c] = d; m_run[c] = int'(cfg_en); m_start[c] = n;
               end else begin
                  m_pend[c] = 1; m_shd[c] = d; m_shen[c] = int'(cfg_en);
               end
            end
         end
      end
   endtask

   function automatic logic [NUM_CH-1:0] exp_clkout();
      logic [NUM_CH-1:0] v = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (m_run[c] != 0) v[c] = (((cyc_n - m_start[c]) % m_d[c]) < ((m_d[c] + 1) / 2));
      end
      return v;
   endfunction

   function automatic logic [NUM_CH-1:0] exp_tick();
      logic [NUM_CH-1:0] v = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (m_run[c] != 0) v[c] = (((cyc_n - m_start[c]) % m_d[c]) == 0);
      end
      return v;
   endfunction

   function automatic logic [NUM_CH-1:0] exp_pending();
      logic [NUM_CH-1:0] v = '0;
      for (int c = 0; c < NUM_CH; c++) v[c] = (m_pend[c] != 0);
      return v;
   endfunction

   function automatic logic exp_ready();
      if (int'(cfg_ch) >= NUM_CH) return 1'b1;
      return (m_pend[cfg_ch] == 0);
   endfunction

   // Compare process: outputs checked against the model mid-cycle.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("clkout",    32'(clkout),    32'(exp_clkout()));
         chk("tick",      32'(tick),      32'(exp_tick()));
         chk("pending",   32'(pending),   32'(exp_pending()));
         chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready()));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic wr(input int ch, input int d, input bit en);
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_div   = 8'(d);
      cfg_en    = en;
      cyc();
      cfg_valid = 1'b0;
   endtask

   logic [11:0] s0, s1, s2;
   int          hi_cnt;
   bit          found;

   initial begin
      // 1. reset with a write and a sync request held active
      rst = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4; cfg_en = 1'b1;
      sync_req = 1'b1;
      cyc(); cyc();
      rst = 1'b0; cfg_valid = 1'b0; sync_req = 1'b0;
      cyc();
      chk("rst_clkout",  32'(clkout),    32'h0);
      chk("rst_tick",    32'(tick),      32'h0);
      chk("rst_pending", 32'(pending),   32'h0);
      chk("rst_ready",   32'(cfg_ready), 32'h1);

      // 2. even ratio on ch0
      wr(0, 4, 1'b1);
      s0 = '0; s1 = '0;
      for (int k = 0; k < 8; k++) begin
         s0 = {s0[10:0], clkout[0]};
         s1 = {s1[10:0], tick[0]};
         cyc();
      end
      chk("d4_clkout", 32'(s0[7:0]), 32'h0CC);
      chk("d4_tick",   32'(s1[7:0]), 32'h088);

      // 3. odd ratio, clamp and maximum ratio
      wr(1, 5, 1'b1);
      s0 = '0;
      for (int k = 0; k < 10; k++) begin
         s0 = {s0[10:0], clkout[1]};
         cyc();
      end
      chk("d5_clkout", 32'(s0[9:0]), 32'(10'b1110011100));
      wr(2, 0, 1'b1);
      s0 = '0;
      for (int k = 0; k < 4; k++) begin
         s0 = {s0[10:0], clkout[2]};
         cyc();
      end
      chk("d0_clamp", 32'(s0[3:0]), 32'(4'b1010));
      wr(2, 1, 1'b1);
      for (int k = 0; k < 4; k++) cyc();
      s0 = '0;
      for (int k = 0; k < 4; k++) begin
         s0 = {s0[10:0], clkout[2]};
         cyc();
      end
      chk("d1_clamp", 32'(s0[3:0] == 4'b1010 || s0[3:0] == 4'b0101), 32'h1);
      wr(3, 255, 1'b1);
      hi_cnt = 0;
      for (int k = 0; k < 255; k++) begin
         if (clkout[3]) hi_cnt++;
         if (k == 127) chk("d255_last_high", 32'(clkout[3]), 32'h1);
         if (k == 128) chk("d255_first_low", 32'(clkout[3]), 32'h0);
         cyc();
      end
      chk("d255_high_count", 32'(hi_cnt), 32'd128);
      chk("d255_wrap_tick",  32'(tick[3]), 32'h1);

      // 4. runtime ratio change on ch0, stalled second write, ch1 accepted
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (!found) begin
            if (tick[0]) found = 1'b1;
            else cyc();
         end
      end
      chk("t4_tick_found", 32'(found), 32'h1);
      s0 = '0;
      s0 = {s0[10:0], clkout[0]};
      cyc();
      s0 = {s0[10:0], clkout[0]};
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6; cfg_en = 1'b1;
      cyc();
      s0 = {s0[10:0], clkout[0]};
      chk("t4_pending0", 32'(pending[0]), 32'h1);
      cfg_div = 8'd3;
      #1;
      chk("t4_stall_ready", 32'(cfg_ready), 32'h0);
      cyc();
      s0 = {s0[10:0], clkout[0]};
      cfg_ch = 2'd1; cfg_div = 8'd5; cfg_en = 1'b0;
      #1;
      chk("t4_ch1_ready", 32'(cfg_ready), 32'h1);
      cyc();
      cfg_valid = 1'b0;
      chk("t4_pending0_clear", 32'(pending[0]), 32'h0);
      for (int k = 0; k < 6; k++) begin
         s0 = {s0[10:0], clkout[0]};
         cyc();
      end
      chk("t4_change_wave", 32'(s0[9:0]), 32'(10'b1100111000));

      // 5. disable of ch1 lands at its wrap, then re-enable
      for (int k = 0; k < 12; k++) cyc();
      chk("t5_off_clkout",  32'(clkout[1]),  32'h0);
      chk("t5_off_tick",    32'(tick[1]),    32'h0);
      chk("t5_off_pending", 32'(pending[1]), 32'h0);
      wr(1, 5, 1'b1);
      chk("t5_reen_clkout", 32'(clkout[1]), 32'h1);
      chk("t5_reen_tick",   32'(tick[1]),   32'h1);

      // 6. sync alignment with a write on the same edge, then mid-period reset
      wr(0, 4, 1'b1);
      wr(1, 6, 1'b1);
      for (int k = 0; k < 15; k++) cyc();
      sync_req = 1'b1;
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3; cfg_en = 1'b1;
      cyc();
      sync_req = 1'b0; cfg_valid = 1'b0;
      chk("t6_sync_clkout", 32'(clkout), 32'hF);
      chk("t6_sync_tick",   32'(tick),   32'hF);
      s0 = '0; s1 = '0; s2 = '0;
      for (int k = 0; k < 12; k++) begin
         s0 = {s0[10:0], clkout[0]};
         s1 = {s1[10:0], clkout[1]};
         s2 = {s2[10:0], clkout[2]};
         cyc();
      end
      chk("t6_ch0_wave", 32'(s0), 32'(12'b110011001100));
      chk("t6_ch1_wave", 32'(s1), 32'(12'b111000111000));
      chk("t6_ch2_wave", 32'(s2), 32'(12'b110110110110));
      cyc(); cyc(); cyc();
      rst = 1'b1;
      cyc();
      chk("t6_rst_clkout",  32'(clkout),  32'h0);
      chk("t6_rst_tick",    32'(tick),    32'h0);
      chk("t6_rst_pending", 32'(pending), 32'h0);
      rst = 1'b0;
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
